// File: rtl/imm_decode_stage.sv
// -----------------------------------------------------------------------------
// imm_decode_stage
//
// Registered immediate-decode stage for the processor front end. Raw
// instructions arrive with their PC over a valid/ready handshake. The
// immediate is decoded combinationally on the input side, sign- or
// zero-extended to XLEN, and classified by format. Illegal or unsupported
// encodings are flagged, and the PC-relative target is precomputed. A
// main/skid register pair decouples upstream ready from downstream ready, so
// in_ready is always a flop output.
//
// Parameters:
//   XLEN   - datapath width, 32 or 64
//   CSR_EN - 1: decode Zicsr forms; 0: SYSTEM with funct3 != 000 is illegal
//
// Ports:
//   clk, rst           - rising-edge clock, asynchronous active-high reset
//   flush              - synchronous discard of both buffered entries
//   in_valid/in_ready  - upstream handshake
//   in_instr, in_pc    - raw instruction and its address
//   out_valid/out_ready- downstream handshake
//   out_instr, out_pc  - passthrough of the buffered instruction and PC
//   out_imm            - decoded immediate (XLEN bits)
//   out_fmt            - 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSRI, 7 SHAMT
//   out_target         - out_pc + out_imm, modulo 2^XLEN
//   out_illegal        - unsupported encoding
// -----------------------------------------------------------------------------
module imm_decode_stage #(
    parameter int XLEN   = 32,
    parameter bit CSR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_CSRI  = 3'd6;
    localparam logic [2:0] FMT_SHAMT = 3'd7;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    // Widen a 32-bit two's-complement immediate to XLEN by sign extension.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = XLEN'($signed(v));
    endfunction

    // Widen a 6-bit unsigned field (shift amounts, CSR zimm) to XLEN.
    function automatic logic [XLEN-1:0] zext6(input logic [5:0] v);
        zext6 = XLEN'(v);
    endfunction

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic            is_shift_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_s;
    logic [XLEN-1:0] imm_b_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] imm_j_s;
    logic [XLEN-1:0] shamt6_s;
    logic [XLEN-1:0] shamt5_s;
    logic [XLEN-1:0] zimm_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [2:0]      dec_fmt_s;
    logic            dec_illegal_s;
    entry_t          new_entry_s;

    entry_t          main_r;
    entry_t          skid_r;
    logic            main_valid_r;
    logic            skid_valid_r;
    logic            in_ready_r;

    logic            accept_s;
    logic            drain_s;
    logic            main_load_new_s;
    logic            main_load_skid_s;
    logic            skid_load_s;
    logic            main_valid_nxt_s;
    logic            skid_valid_nxt_s;

    assign opcode_s   = in_instr[6:0];
    assign funct3_s   = in_instr[14:12];
    assign is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);

    assign imm_i_s  = sext32({{20{in_instr[31]}}, in_instr[31:20]});
    assign imm_s_s  = sext32({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
    assign imm_b_s  = sext32({{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0});
    assign imm_u_s  = sext32({in_instr[31:12], 12'b0});
    assign imm_j_s  = sext32({{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0});
    assign shamt6_s = zext6(in_instr[25:20]);
    assign shamt5_s = zext6({1'b0, in_instr[24:20]});
    assign zimm_s   = zext6({1'b0, in_instr[19:15]});

    // Immediate decode: format, extended value and legality from the raw word.
    // Illegal encodings leave fmt NONE and imm 0.
    always_comb begin
        dec_imm_s     = '0;
        dec_fmt_s     = FMT_NONE;
        dec_illegal_s = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal_s = 1'b1;
        end else begin
            case (opcode_s)
                OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                    dec_fmt_s = FMT_I;
                    dec_imm_s = imm_i_s;
                end
                OPC_OPIMM: begin
                    if (!is_shift_s) begin
                        dec_fmt_s = FMT_I;
                        dec_imm_s = imm_i_s;
                    end else if (XLEN == 64) begin
                        dec_fmt_s = FMT_SHAMT;
                        dec_imm_s = shamt6_s;
                    end else if (in_instr[25]) begin
                        // RV32 shifts only have 5 shamt bits.
                        dec_illegal_s = 1'b1;
                    end else begin
                        dec_fmt_s = FMT_SHAMT;
                        dec_imm_s = shamt5_s;
                    end
                end
                OPC_OPIMM32: begin
                    if (XLEN != 64) begin
                        dec_illegal_s = 1'b1;
                    end else if (!is_shift_s) begin
                        dec_fmt_s = FMT_I;
                        dec_imm_s = imm_i_s;
                    end else if (in_instr[25]) begin
                        // Word shifts are 5-bit even on RV64.
                        dec_illegal_s = 1'b1;
                    end else begin
                        dec_fmt_s = FMT_SHAMT;
                        dec_imm_s = shamt5_s;
                    end
                end
                OPC_OP32: begin
                    if (XLEN != 64) begin
                        dec_illegal_s = 1'b1;
                    end else begin
                        dec_fmt_s = FMT_NONE;
                    end
                end
                OPC_STORE: begin
                    dec_fmt_s = FMT_S;
                    dec_imm_s = imm_s_s;
                end
                OPC_BRANCH: begin
                    dec_fmt_s = FMT_B;
                    dec_imm_s = imm_b_s;
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_fmt_s = FMT_U;
                    dec_imm_s = imm_u_s;
                end
                OPC_JAL: begin
                    dec_fmt_s = FMT_J;
                    dec_imm_s = imm_j_s;
                end
                OPC_OP: begin
                    dec_fmt_s = FMT_NONE;
                end
                OPC_SYSTEM: begin
                    case (funct3_s)
                        3'b000: begin
                            dec_fmt_s = FMT_I;
                            dec_imm_s = imm_i_s;
                        end
                        3'b001, 3'b010, 3'b011: begin
                            if (CSR_EN) begin
                                dec_fmt_s = FMT_I;
                                dec_imm_s = imm_i_s;
                            end else begin
                                dec_illegal_s = 1'b1;
                            end
                        end
                        3'b101, 3'b110, 3'b111: begin
                            if (CSR_EN) begin
                                dec_fmt_s = FMT_CSRI;
                                dec_imm_s = zimm_s;
                            end else begin
                                dec_illegal_s = 1'b1;
                            end
                        end
                        default: begin
                            dec_illegal_s = 1'b1;
                        end
                    endcase
                end
                default: begin
                    dec_illegal_s = 1'b1;
                end
            endcase
        end
    end

    // Assemble the entry that would be captured this cycle, target included.
    always_comb begin
        new_entry_s.instr   = in_instr;
        new_entry_s.pc      = in_pc;
        new_entry_s.imm     = dec_imm_s;
        new_entry_s.fmt     = dec_fmt_s;
        new_entry_s.target  = in_pc + dec_imm_s;
        new_entry_s.illegal = dec_illegal_s;
    end

    assign accept_s = in_valid && in_ready_r;
    assign drain_s  = main_valid_r && out_ready;

    // Buffer next-state: which register loads what, and the new valid bits.
    // The skid can only be non-empty while main is full.
    always_comb begin
        main_load_new_s  = 1'b0;
        main_load_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        main_valid_nxt_s = main_valid_r;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            main_valid_nxt_s = 1'b0;
            skid_valid_nxt_s = 1'b0;
        end else if (!main_valid_r) begin
            if (accept_s) begin
                main_load_new_s  = 1'b1;
                main_valid_nxt_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else if (drain_s) begin
            if (skid_valid_r) begin
                // in_ready is low here, so no beat can arrive alongside.
                main_load_skid_s = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
                main_load_new_s = 1'b1;
            end else begin
                main_valid_nxt_s = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_load_s      = 1'b1;
                skid_valid_nxt_s = 1'b1;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
            end
        end
    end

    // Buffer state: valid bits, registered in_ready and entry payloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            main_r       <= '0;
            skid_r       <= '0;
        end else begin
            main_valid_r <= main_valid_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
            if (main_load_new_s) begin
                main_r <= new_entry_s;
            end else if (main_load_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (skid_load_s) begin
                skid_r <= new_entry_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = main_valid_r;
    assign out_instr   = main_r.instr;
    assign out_pc      = main_r.pc;
    assign out_imm     = main_r.imm;
    assign out_fmt     = main_r.fmt;
    assign out_target  = main_r.target;
    assign out_illegal = main_r.illegal;

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised immediate-decode stage for the processor front end. It accepts raw instructions with their PC over a valid/ready handshake and decodes the immediate sign- or zero-extended to XLEN. It also classifies the immediate format, flags illegal or unsupported encodings, and precomputes the PC-relative target. A two-entry skid buffer sits between fetch and the register-read/execute path, so it can be inserted into a pipelined core without combinational ready paths.

## Interface
Parameters:
- XLEN, 32: datapath width; only 32 and 64 are legal.
- CSR_EN, 1: 1 decodes Zicsr forms; 0 flags SYSTEM with funct3≠000 as illegal.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous; discards all buffered entries.
- in_valid, input, 1: upstream beat valid.
- in_ready, output, 1: stage can accept a beat.
- in_instr, input, 32: raw instruction.
- in_pc, input, XLEN: instruction address.
- out_valid, output, 1: decoded beat valid.
- out_ready, input, 1: downstream accepts the beat.
- out_instr, output, 32: instruction passthrough.
- out_pc, output, XLEN: PC passthrough.
- out_imm, output, XLEN: decoded immediate.
- out_fmt, output, 3: format tag, 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSRI, 7 SHAMT.
- out_target, output, XLEN: out_pc + out_imm, modulo 2^XLEN.
- out_illegal, output, 1: unsupported encoding.

## Operation
- Decode table (s = sign-extend to XLEN from instr[31]):
  - Loads 0000011, JALR 1100111, FENCE 0001111: I, s(instr[31:20]).
  - OP-IMM 0010011 with funct3 ∉ {001,101}: I, s(instr[31:20]).
  - OP-IMM with funct3 ∈ {001,101}: SHAMT, zero-extended.
    - XLEN=64: shamt = instr[25:20].
    - XLEN=32: shamt = instr[24:20]; instr[25]=1 is illegal.
  - Store 0100011: S, s({instr[31:25],instr[11:7]}).
  - Branch 1100011: B, s({instr[31],instr[7],instr[30:25],instr[11:8],0}).
  - LUI 0110111 / AUIPC 0010111: U, s({instr[31:12],12'b0}).
  - JAL 1101111: J, s({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - OP 0110011: NONE, imm 0.
  - SYSTEM 1110011:
    - funct3 000: I.
    - CSR_EN=1, funct3 ∈ {001,010,011}: I.
    - CSR_EN=1, funct3 ∈ {101,110,111}: CSRI, zero-extend(instr[19:15]).
    - CSR_EN=0 and funct3≠000: illegal.
    - funct3 100: illegal.
  - OP-IMM-32 0011011 / OP-32 0111011: decoded as I/SHAMT/NONE only when XLEN=64.
    - OP-IMM-32 shift: 5-bit shamt; instr[25]=1 is illegal.
    - XLEN=32: both opcodes are illegal.
- Any other opcode, or instr[1:0]≠11: out_illegal=1, fmt NONE, imm 0.
- out_target is computed at load time and registered.
- Buffer: main register plus skid register.
  - in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
  - Accept when in_valid && in_ready; drain when out_valid && out_ready.
  - Empty + accept → main loads.
  - Main full, no drain, accept → skid loads.
  - Drain with skid full → skid moves to main; any simultaneous accept is impossible because in_ready=0.
  - Drain + accept with skid empty → main reloads with the new beat.
- flush: both entries invalidated next edge; a beat accepted in the flush cycle is discarded. flush has priority over accept and drain.

## Timing
- Reset (asynchronous, immediate): out_valid=0, skid empty, in_ready=1, all data outputs 0.
- Latency: 1 cycle from accept into an empty stage to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- While out_valid && !out_ready, all out_* hold stable.
- in_ready drops the cycle after the skid fills and rises the cycle after it empties.
- Reset mid-stream drops all beats; out_valid returns to 0 the same cycle rst rises.
- Decode is combinational on in_instr before the registers; no extra latency.

## Test plan
- Reset: assert rst mid-stream → out_valid=0, in_ready=1, out_imm=0 without a clock edge.
- XLEN=32, addi x1,x0,-1 (0xFFF00093), pc 0x100, out_ready=1 → next cycle out_imm=0xFFFFFFFF, fmt 1, out_target=0x000000FF.
- XLEN=64, beq offset -4 (0xFE000EE3), pc 0x1000 → out_imm=0xFFFFFFFFFFFFFFFC, fmt 3, out_target=0xFFC.
- XLEN=32:
  - slli with instr[25]=1 (0x02009093) → out_illegal=1.
  - 0x0000001B (OP-IMM-32) → out_illegal=1.
- CSR_EN=1, csrrwi with zimm=31 (0x340FD073) → out_imm=0x1F, fmt 6. Same instruction with CSR_EN=0 → out_illegal=1.
- Backpressure: hold out_ready=0 and push 3 beats → two accepted, in_ready=0 from the third cycle, outputs stable.
  - Release out_ready → beats emerge in order, one per cycle.
  - Assert flush with both entries full → out_valid=0 next cycle.
